// File: rtl/c5_mem_sched.sv
// Memory scheduler: arbitrates CPU, video and refresh onto one SDRAM command stream.
// Owns the refresh tick generator and the refresh debt counter.
module c5_mem_sched #(
  parameter int ADDR_W         = 23,
  parameter int REFRESH_CYCLES = 720,
  parameter int MAX_PENDING    = 8,
  parameter int URGENT_PENDING = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_cpu_select,
  input  logic [29:0]       I_cpu_address,
  input  logic [3:0]        I_cpu_byte_we,
  input  logic [31:0]       I_cpu_data_write,
  output logic [31:0]       O_cpu_data_read,
  output logic              O_cpu_pause,
  output logic              O_cpu_data_ready,
  input  logic              I_vid_req,
  input  logic [ADDR_W-1:0] I_vid_address,
  output logic              O_vid_ack,
  output logic [31:0]       O_vid_data,
  output logic              O_vid_valid,
  output logic              O_cmd_read,
  output logic              O_cmd_write,
  output logic              O_cmd_refresh,
  output logic [ADDR_W-1:0] O_address,
  output logic [31:0]       O_data_in,
  output logic [3:0]        O_byte_we,
  input  logic [31:0]       I_data_out,
  input  logic              I_data_ready,
  input  logic              I_busy,
  output logic              O_refresh_overrun
);
  localparam int TICK_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DEBT_W = $clog2(MAX_PENDING + 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(REFRESH_CYCLES - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX    = DEBT_W'(MAX_PENDING);
  localparam logic [DEBT_W-1:0] DEBT_URGENT = DEBT_W'(URGENT_PENDING);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_REF} owner_t;

  state_t            state, state_next;
  owner_t            owner, grant;
  logic [TICK_W-1:0] tick_cnt;
  logic [DEBT_W-1:0] debt;
  logic              tick, ref_accept, is_read, leave_wait, first_wait, cpu_req;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, cpu_rdata, vid_rdata;
  logic [3:0]        we_q;
  logic              cpu_ready, vid_valid, overrun;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^(I_cpu_address >> ADDR_W);

  assign tick       = (tick_cnt == TICK_LAST);
  assign ref_accept = (state == ISSUE) && (owner == OWN_REF) && !I_busy;
  assign is_read    = (owner == OWN_VID) || ((owner == OWN_CPU) && (we_q == 4'b0000));
  // Reads finish on returned data; writes/refresh skip the first WAIT cycle before trusting busy.
  assign leave_wait = is_read ? I_data_ready : (!first_wait && !I_busy);
  assign cpu_req    = I_cpu_select && !cpu_ready;

  always_comb begin
    grant = OWN_NONE;
    if (!I_rst && state == IDLE) begin
      if (debt >= DEBT_URGENT)  grant = OWN_REF;
      else if (I_vid_req)       grant = OWN_VID;
      else if (cpu_req)         grant = OWN_CPU;
      else if (debt != '0)      grant = OWN_REF;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant != OWN_NONE) state_next = ISSUE;
      ISSUE:   if (!I_busy)           state_next = WAIT;
      WAIT:    if (leave_wait)        state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      tick_cnt <= '0;
      debt     <= '0;
      overrun  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && !ref_accept) begin
        if (debt == DEBT_MAX) overrun <= 1'b1;
        else                  debt    <= debt + 1'b1;
      end else if (!tick && ref_accept) begin
        debt <= debt - 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      first_wait <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
      cpu_ready  <= 1'b0;
      vid_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      first_wait <= (state == ISSUE);
      cpu_ready  <= (state == WAIT) && leave_wait && (owner == OWN_CPU);
      vid_valid  <= (state == WAIT) && leave_wait && (owner == OWN_VID);
      if (grant != OWN_NONE) begin
        owner   <= grant;
        addr_q  <= '0;
        wdata_q <= '0;
        we_q    <= '0;
        if (grant == OWN_CPU) begin
          addr_q <= I_cpu_address[ADDR_W-1:0];
          we_q   <= I_cpu_byte_we;
          if (I_cpu_byte_we != 4'b0000) wdata_q <= I_cpu_data_write;
        end else if (grant == OWN_VID) begin
          addr_q <= I_vid_address;
        end
      end
      if ((state == WAIT) && leave_wait && is_read) begin
        if (owner == OWN_CPU) cpu_rdata <= I_data_out;
        else                  vid_rdata <= I_data_out;
      end
    end
  end

  assign O_cmd_read        = (state == ISSUE) && is_read;
  assign O_cmd_write       = (state == ISSUE) && (owner == OWN_CPU) && (we_q != 4'b0000);
  assign O_cmd_refresh     = (state == ISSUE) && (owner == OWN_REF);
  assign O_address         = addr_q;
  assign O_data_in         = wdata_q;
  assign O_byte_we         = we_q;
  assign O_cpu_data_read   = cpu_rdata;
  assign O_cpu_data_ready  = cpu_ready;
  assign O_cpu_pause       = !I_rst && cpu_req;
  assign O_vid_ack         = (grant == OWN_VID);
  assign O_vid_data        = vid_rdata;
  assign O_vid_valid       = vid_valid;
  assign O_refresh_overrun = overrun;
endmodule

// File: tb/tb_c5_mem_sched.sv
`timescale 1ns/1ps
// Directed bench for c5_mem_sched: small SDRAM responder, completion scoreboards, refresh timing.
module tb_c5_mem_sched;
  localparam int ADDR_W = 23;
  localparam int RC     = 16;
  localparam int OWN_R = 0, OWN_V = 1, OWN_C = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_select = 1'b0;
  logic [29:0]       cpu_address = '0;
  logic [3:0]        cpu_byte_we = '0;
  logic [31:0]       cpu_data_write = '0;
  logic [31:0]       cpu_data_read;
  logic              cpu_pause, cpu_data_ready;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_address = '0;
  logic              vid_ack, vid_valid;
  logic [31:0]       vid_data;
  logic              cmd_read, cmd_write, cmd_refresh;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [3:0]        byte_we;
  logic [31:0]       data_out = '0;
  logic              data_ready = 1'b0;
  logic              busy = 1'b0;
  logic              refresh_overrun;

  c5_mem_sched #(.ADDR_W(ADDR_W), .REFRESH_CYCLES(RC), .MAX_PENDING(8), .URGENT_PENDING(4)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_cpu_select(cpu_select), .I_cpu_address(cpu_address), .I_cpu_byte_we(cpu_byte_we),
    .I_cpu_data_write(cpu_data_write), .O_cpu_data_read(cpu_data_read), .O_cpu_pause(cpu_pause),
    .O_cpu_data_ready(cpu_data_ready),
    .I_vid_req(vid_req), .I_vid_address(vid_address), .O_vid_ack(vid_ack), .O_vid_data(vid_data),
    .O_vid_valid(vid_valid),
    .O_cmd_read(cmd_read), .O_cmd_write(cmd_write), .O_cmd_refresh(cmd_refresh),
    .O_address(address), .O_data_in(data_in), .O_byte_we(byte_we),
    .I_data_out(data_out), .I_data_ready(data_ready), .I_busy(busy),
    .O_refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // SDRAM responder: busy for two cycles after each accept, read data two cycles after accept.
  logic [31:0] mem [logic [ADDR_W-1:0]];
  logic [31:0] rd_data = '0, merge = '0;
  int busy_until = -1, rd_at = -1;
  logic force_busy = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      busy_until = -1; rd_at = -1;
      busy = 1'b0; data_ready = 1'b0; data_out = '0;
    end else begin
      busy       = force_busy || (cyc <= busy_until);
      data_ready = (cyc == rd_at);
      data_out   = data_ready ? rd_data : 32'h0;
      if ((cmd_read || cmd_write || cmd_refresh) && !busy) begin
        busy_until = cyc + 2;
        if (cmd_read) begin
          rd_at   = cyc + 2;
          rd_data = mem.exists(address) ? mem[address] : {9'h0, address};
        end
        if (cmd_write) begin
          merge = mem.exists(address) ? mem[address] : {9'h0, address};
          for (int b = 0; b < 4; b++) if (byte_we[b]) merge[8*b +: 8] = data_in[8*b +: 8];
          mem[address] = merge;
        end
      end
    end
  end

  typedef struct packed { logic is_read; logic [31:0] data; } exp_t;
  exp_t        cpu_q[$];
  logic [31:0] vid_q[$];
  int          log_q[$];
  int          ref_cnt = 0, cpu_acc_cnt = 0, last_ref_cyc = 0;
  bit          vid_granted = 1'b0;
  logic              last_is_write = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0, last_vid_addr = '0;
  logic [31:0]       last_din = '0;
  logic [3:0]        last_we = '0;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) vid_granted = 1'b0;
    else begin
      if (vid_ack) vid_granted = 1'b1;
      if ((cmd_read || cmd_write || cmd_refresh) && !busy) begin
        check("cmd_onehot", 32'($countones({cmd_read, cmd_write, cmd_refresh})), 1);
        if (cmd_refresh) begin
          ref_cnt++; last_ref_cyc = cyc; log_q.push_back(OWN_R);
          check("refresh_din_zero", data_in, 0);
          check("refresh_we_zero", {28'h0, byte_we}, 0);
        end else if (cmd_read && vid_granted) begin
          vid_granted = 1'b0; last_vid_addr = address; log_q.push_back(OWN_V);
          check("vid_read_we_zero", {28'h0, byte_we}, 0);
        end else begin
          cpu_acc_cnt++; log_q.push_back(OWN_C);
          last_is_write = cmd_write; last_addr = address; last_din = data_in; last_we = byte_we;
        end
      end
      if (cpu_data_ready) begin
        check("cpu_ready_expected", 32'(cpu_q.size() != 0), 1);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          if (e.is_read) check("cpu_read_data", cpu_data_read, e.data);
        end
      end
      if (vid_valid) begin
        check("vid_valid_expected", 32'(vid_q.size() != 0), 1);
        if (vid_q.size() != 0) check("vid_data", vid_data, vid_q.pop_front());
      end
    end
  end

  task automatic wait_ref(input string tag);
    int n0;
    bit got;
    n0 = ref_cnt; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #2;
      if (ref_cnt != n0) got = 1'b1;
    end
    check(tag, 32'(got), 1);
  endtask

  task automatic cpu_access(input string tag, input logic [31:0] byte_addr, input logic [3:0] we,
                            input logic [31:0] wdata, input logic [31:0] exp_rd);
    bit done, pause_bad;
    @(negedge clk);
    cpu_select = 1'b1; cpu_address = byte_addr[31:2]; cpu_byte_we = we; cpu_data_write = wdata;
    cpu_q.push_back('{is_read: (we == 4'b0000), data: exp_rd});
    done = 1'b0; pause_bad = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cpu_data_ready) done = 1'b1;
      else if (!cpu_pause) pause_bad = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_pause_held"}, 32'(pause_bad), 0);
    check({tag, "_pause_at_ready"}, 32'(cpu_pause), 0);
    cpu_select = 1'b0; cpu_byte_we = '0; cpu_data_write = '0;
  endtask

  task automatic vid_and_cpu(input string tag, input logic [ADDR_W-1:0] vaddr, input logic [31:0] vexp,
                             input logic [31:0] cbyte, input logic [31:0] cexp, input bit hold_busy);
    bit acked, vdone, cdone, pause_bad;
    acked = 1'b0; vdone = 1'b0; cdone = 1'b0; pause_bad = 1'b0;
    vid_req = 1'b1; vid_address = vaddr; vid_q.push_back(vexp);
    cpu_select = 1'b1; cpu_address = cbyte[31:2]; cpu_byte_we = 4'b0000;
    cpu_q.push_back('{is_read: 1'b1, data: cexp});
    if (hold_busy) begin
      repeat (3) @(negedge clk);
      force_busy = 1'b0;
    end
    for (int i = 0; i < 300 && !(vdone && cdone); i++) begin
      @(negedge clk);
      if (acked && vid_req) vid_req = 1'b0;
      if (vid_ack) acked = 1'b1;
      if (vid_valid) vdone = 1'b1;
      if (cpu_data_ready) begin cdone = 1'b1; cpu_select = 1'b0; end
      else if (cpu_select && !cpu_pause) pause_bad = 1'b1;
    end
    vid_req = 1'b0; cpu_select = 1'b0;
    check({tag, "_vid_done"}, 32'(vdone), 1);
    check({tag, "_cpu_done"}, 32'(cdone), 1);
    check({tag, "_pause_held"}, 32'(pause_bad), 0);
    check({tag, "_vid_addr"}, 32'(last_vid_addr), 32'(vaddr));
  endtask

  function automatic int first_pos(input int who, input int from);
    for (int i = from; i < log_q.size(); i++) if (log_q[i] == who) return i;
    return 32'h7fff_ffff;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, prev, mark;
    bit got;
    mem[23'h400] = 32'hDEADBEEF;
    mem[23'h800] = 32'hAABBCCDD;
    mem[23'h123] = 32'hCAFEF00D;
    mem[23'hC00] = 32'h0BADF00D;

    #12;
    check("rst_cmds", {29'h0, cmd_read, cmd_write, cmd_refresh}, 0);
    check("rst_address", 32'(address), 0);
    check("rst_cpu_pause", 32'(cpu_pause), 0);
    check("rst_cpu_ready", 32'(cpu_data_ready), 0);
    check("rst_vid_ack", 32'(vid_ack), 0);
    check("rst_overrun", 32'(refresh_overrun), 0);

    // Idle ports: one refresh every RC cycles, debt back to zero after each.
    @(negedge clk); rst = 1'b0; c0 = cyc;
    wait_ref("first_refresh_seen");
    check("first_refresh_time", 32'(last_ref_cyc - c0), 17);
    @(negedge clk); check("debt_after_refresh0", 32'(dut.debt), 0);
    prev = last_ref_cyc;
    for (int k = 0; k < 3; k++) begin
      wait_ref("refresh_seen");
      check("refresh_period", 32'(last_ref_cyc - prev), RC);
      prev = last_ref_cyc;
      @(negedge clk); check("debt_after_refresh", 32'(dut.debt), 0);
    end

    // CPU read, CPU partial write, read-back of the merged word.
    cpu_access("cpu_read", 32'h0000_1000, 4'b0000, 32'h0, 32'hDEADBEEF);
    check("rd_cmd_is_read", 32'(last_is_write), 0);
    check("rd_cmd_addr", 32'(last_addr), 32'h400);
    check("rd_cmd_din_zero", last_din, 0);
    cpu_access("cpu_write", 32'h0000_2000, 4'b0011, 32'h12345678, 32'h0);
    check("wr_cmd_is_write", 32'(last_is_write), 1);
    check("wr_cmd_addr", 32'(last_addr), 32'h800);
    check("wr_cmd_din", last_din, 32'h12345678);
    check("wr_cmd_we", {28'h0, last_we}, 32'h3);
    cpu_access("cpu_readback", 32'h0000_2000, 4'b0000, 32'h0, 32'hAABB5678);

    // Video and CPU requests rise together: video wins, CPU follows.
    @(negedge clk); mark = log_q.size();
    vid_and_cpu("vc", 23'h123, 32'hCAFEF00D, 32'h0000_3000, 32'h0BADF00D, 1'b0);
    check("vc_video_first", 32'(first_pos(OWN_V, mark) < first_pos(OWN_C, mark)), 1);

    // Five ticks of busy: debt 5, urgent refreshes precede video and CPU.
    repeat (40) @(negedge clk);
    check("no_overrun_yet", 32'(refresh_overrun), 0);
    force_busy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); if (dut.debt == 5) got = 1'b1; end
    check("debt_reached_5", 32'(got), 1);
    mark = log_q.size();
    vid_and_cpu("urg", 23'h124, 32'h0000_0124, 32'h0000_1000, 32'hDEADBEEF, 1'b1);
    check("urg_first_refresh", 32'(log_q.size() > mark ? log_q[mark] : -1), OWN_R);
    check("urg_second_refresh", 32'(log_q.size() > mark + 1 ? log_q[mark + 1] : -1), OWN_R);
    check("urg_video_before_cpu", 32'(first_pos(OWN_V, mark) < first_pos(OWN_C, mark)), 1);
    check("urg_no_overrun", 32'(refresh_overrun), 0);

    // Nine ticks of busy: saturate at 8 and flag overrun.
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); if (dut.debt == 0) got = 1'b1; end
    check("debt_drained", 32'(got), 1);
    force_busy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); if (dut.debt == 8) got = 1'b1; end
    check("debt_reached_8", 32'(got), 1);
    check("overrun_before_9th", 32'(refresh_overrun), 0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (refresh_overrun) got = 1'b1; end
    check("overrun_set", 32'(got), 1);
    check("debt_saturated", 32'(dut.debt), 8);
    force_busy = 1'b0;
    repeat (100) @(negedge clk);
    check("overrun_sticky", 32'(refresh_overrun), 1);

    // Reset during the WAIT of a CPU read aborts it without a completion pulse.
    c0 = cpu_acc_cnt;
    @(negedge clk); cpu_select = 1'b1; cpu_address = 30'h400; cpu_byte_we = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); #2; if (cpu_acc_cnt != c0) got = 1'b1; end
    check("abort_read_issued", 32'(got), 1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("abort_cmds", {29'h0, cmd_read, cmd_write, cmd_refresh}, 0);
    check("abort_address", 32'(address), 0);
    check("abort_pause", 32'(cpu_pause), 0);
    check("abort_cpu_data", cpu_data_read, 0);
    check("abort_vid_data", vid_data, 0);
    check("abort_overrun", 32'(refresh_overrun), 0);
    cpu_select = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; c0 = cyc;
    wait_ref("post_reset_refresh_seen");
    check("post_reset_refresh_time", 32'(last_ref_cyc - c0), 17);
    @(negedge clk); check("post_reset_debt", 32'(dut.debt), 0);
    repeat (30) @(negedge clk);
    check("cpu_queue_empty", 32'(cpu_q.size()), 0);
    check("vid_queue_empty", 32'(vid_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
